// File: rtl/dram_frame_reader.sv
// Fetches one frame from the front SDRAM buffer into the display FIFO, one read burst at a time.
// Latency: vsync_start -> rd_req in 2 cycles; each rd_data beat reaches fifo_wr 1 cycle later.
// Backpressure: a burst is requested only when the FIFO can absorb all of it; rd_req is held until rd_ack.
module dram_frame_reader #(
    parameter logic [22:0] BUFFER_A    = 23'h00000,
    parameter logic [22:0] BUFFER_B    = 23'h4B000,
    parameter int          FRAME_WORDS = 307200,
    parameter int          BURST_LEN   = 8,
    parameter int          FIFO_DEPTH  = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync_start,
    input  logic        wr_frame_done,
    input  logic [11:0] fifo_wrusedw,
    input  logic        fifo_wrfull,
    output logic        fifo_wr,
    output logic [15:0] fifo_data,
    output logic        rd_req,
    input  logic        rd_ack,
    output logic [22:0] rd_addr,
    output logic [1:0]  BA,
    input  logic        rd_data_valid,
    input  logic [15:0] rd_data,
    output logic        buffer_select,
    output logic        frame_busy,
    output logic        frame_end,
    output logic [1:0]  err_flags
);

    localparam int          WC_W      = $clog2(FRAME_WORDS + 1);
    localparam int          BC_W      = $clog2(BURST_LEN + 1);
    localparam logic [12:0] SPACE_LIM = 13'(FIFO_DEPTH - BURST_LEN);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        REQ,
        DATA
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic              swap_pend_q, swap_pend_d;
    logic              buf_sel_q, buf_sel_d;
    logic              busy_q, busy_d;
    logic              rd_req_q, rd_req_d;
    logic [22:0]       rd_addr_q, rd_addr_d;
    logic              fifo_wr_q, fifo_wr_d;
    logic [15:0]       fifo_data_q, fifo_data_d;
    logic              frame_end_q, frame_end_d;
    logic [1:0]        err_q, err_d;

    logic              space;
    logic [22:0]       base;
    logic [WC_W-1:0]   word_cnt_nxt;

    // Reserve a whole burst of FIFO space so the write side can never overflow.
    assign space        = ~fifo_wrfull && ({1'b0, fifo_wrusedw} < SPACE_LIM);
    assign base         = buf_sel_q ? BUFFER_B : BUFFER_A;
    assign word_cnt_nxt = word_cnt_q + WC_W'(BURST_LEN);

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        swap_pend_d = swap_pend_q;
        buf_sel_d   = buf_sel_q;
        busy_d      = busy_q;
        rd_req_d    = rd_req_q;
        rd_addr_d   = rd_addr_q;
        fifo_wr_d   = 1'b0;
        fifo_data_d = fifo_data_q;
        frame_end_d = 1'b0;
        err_d       = err_q;

        if (wr_frame_done) begin
            swap_pend_d = 1'b1;
        end
        if (vsync_start && (state_q != IDLE)) begin
            err_d[0] = 1'b1;
        end
        if (rd_data_valid && (state_q != DATA)) begin
            err_d[1] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (vsync_start) begin
                    // A frame-done pulse arriving with vsync is consumed by this swap.
                    if (swap_pend_q || wr_frame_done) begin
                        buf_sel_d   = ~buf_sel_q;
                        swap_pend_d = 1'b0;
                    end
                    word_cnt_d = '0;
                    beat_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (space) begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = base + 23'(word_cnt_q);
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (rd_ack) begin
                    rd_req_d   = 1'b0;
                    beat_cnt_d = '0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (rd_data_valid) begin
                    fifo_wr_d   = 1'b1;
                    fifo_data_d = rd_data;
                    if (beat_cnt_q == BC_W'(BURST_LEN - 1)) begin
                        beat_cnt_d = '0;
                        word_cnt_d = word_cnt_nxt;
                        if (word_cnt_nxt == WC_W'(FRAME_WORDS)) begin
                            busy_d      = 1'b0;
                            frame_end_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            state_d = CHECK;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            swap_pend_q <= 1'b0;
            buf_sel_q   <= 1'b0;
            busy_q      <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            fifo_wr_q   <= 1'b0;
            fifo_data_q <= '0;
            frame_end_q <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            swap_pend_q <= swap_pend_d;
            buf_sel_q   <= buf_sel_d;
            busy_q      <= busy_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_data_q <= fifo_data_d;
            frame_end_q <= frame_end_d;
            err_q       <= err_d;
        end
    end

    assign fifo_wr       = fifo_wr_q;
    assign fifo_data     = fifo_data_q;
    assign rd_req        = rd_req_q;
    assign rd_addr       = rd_addr_q;
    assign BA            = 2'b00;
    assign buffer_select = buf_sel_q;
    assign frame_busy    = busy_q;
    assign frame_end     = frame_end_q;
    assign err_flags     = err_q;

endmodule

// File: tb/tb_dram_frame_reader.sv
// Bench for dram_frame_reader; frame size is shrunk to 32 bursts so whole frames stay short.
module tb_dram_frame_reader;

    localparam int          TB_FRAME = 256;
    localparam int          BL       = 8;
    localparam int          NB       = TB_FRAME / BL;
    localparam logic [22:0] BUF_A    = 23'h00000;
    localparam logic [22:0] BUF_B    = 23'h4B000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        vsync_start = 1'b0;
    logic        wr_frame_done = 1'b0;
    logic [11:0] fifo_wrusedw = '0;
    logic        fifo_wrfull = 1'b0;
    logic        rd_ack = 1'b0;
    logic        rd_data_valid = 1'b0;
    logic [15:0] rd_data = '0;
    logic        fifo_wr;
    logic [15:0] fifo_data;
    logic        rd_req;
    logic [22:0] rd_addr;
    logic [1:0]  BA;
    logic        buffer_select;
    logic        frame_busy;
    logic        frame_end;
    logic [1:0]  err_flags;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr  = 0;
    int n_fe  = 0;
    bit sb_en = 1'b1;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;

    dram_frame_reader #(.FRAME_WORDS(TB_FRAME)) dut (
        .clk(clk), .reset(reset), .vsync_start(vsync_start), .wr_frame_done(wr_frame_done),
        .fifo_wrusedw(fifo_wrusedw), .fifo_wrfull(fifo_wrfull), .fifo_wr(fifo_wr),
        .fifo_data(fifo_data), .rd_req(rd_req), .rd_ack(rd_ack), .rd_addr(rd_addr), .BA(BA),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data), .buffer_select(buffer_select),
        .frame_busy(frame_busy), .frame_end(frame_end), .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    // Scoreboard: every FIFO write must match the oldest beat driven into DATA.
    always @(negedge clk) begin
        if (sb_en && fifo_wr) begin
            n_wr++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL fifo_data: unexpected write %h, nothing expected", fifo_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (fifo_data !== mon_exp) begin
                    n_bad++;
                    $display("FAIL fifo_data: got %h expected %h", fifo_data, mon_exp);
                end
            end
        end
        if (sb_en && frame_end) begin
            n_fe++;
            n_cmp++;
            if (frame_busy !== 1'b0 || fifo_wr !== 1'b1) begin
                n_bad++;
                $display("FAIL frame_end_align: busy=%b wr=%b expected busy=0 wr=1", frame_busy, fifo_wr);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        vsync_start = 0; wr_frame_done = 0; rd_ack = 0; rd_data_valid = 0;
        fifo_wrusedw = 0; fifo_wrfull = 0;
        reset = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        exp_q.delete();
    endtask

    task automatic pulse_vsync();
        vsync_start = 1;
        @(posedge clk);
        #1 vsync_start = 0;
    endtask

    // Waits for a request, acks it, then returns BL beats; optionally pulses vsync/frame-done on a beat.
    task automatic serve_burst(input int vs_beat, input int wfd_beat,
                               output logic [22:0] addr, output bit ok);
        int t = 0;
        logic [15:0] d;
        ok = 1;
        addr = '0;
        @(negedge clk);
        while (rd_req !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (rd_req !== 1'b1) begin
            ok = 0;
            return;
        end
        addr = rd_addr;
        @(posedge clk); #1 rd_ack = 1;
        @(posedge clk); #1 rd_ack = 0;
        for (int b = 0; b < BL; b++) begin
            d = 16'($urandom);
            rd_data = d;
            rd_data_valid = 1;
            exp_q.push_back(d);
            vsync_start = (b == vs_beat);
            wr_frame_done = (b == wfd_beat);
            @(posedge clk); #1;
        end
        rd_data_valid = 0; vsync_start = 0; wr_frame_done = 0;
    endtask

    // Serves a whole frame; counts bursts whose address or buffer select differ from the expected.
    task automatic run_frame(input logic [22:0] base, input logic sel, input int wfd_b1,
                             input int wfd_b2, output int bursts, output int bad,
                             output logic [22:0] last_a);
        logic [22:0] a;
        bit ok;
        bursts = 0; bad = 0; last_a = '0;
        for (int i = 0; i < NB; i++) begin
            serve_burst(-1, (i == wfd_b1 || i == wfd_b2) ? 4 : -1, a, ok);
            if (!ok) begin
                bad++;
                break;
            end
            bursts++;
            last_a = a;
            if (a !== base + 23'(i * BL) || buffer_select !== sel) bad++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int t = 0;
        do_reset();
        @(negedge clk);
        n_cmp++;
        if ({rd_req, fifo_wr, fifo_data, rd_addr, buffer_select, frame_busy, frame_end, err_flags, BA} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: req=%b wr=%b dat=%h addr=%h sel=%b busy=%b fe=%b err=%b ba=%b, all must be 0",
                     rd_req, fifo_wr, fifo_data, rd_addr, buffer_select, frame_busy, frame_end, err_flags, BA);
        end
        @(posedge clk); #1;
        sb_en = 0;
        pulse_vsync();
        while (rd_req !== 1'b1 && t < 50) begin
            @(posedge clk); #1; t++;
        end
        @(posedge clk); #1 rd_ack = 1;
        @(posedge clk); #1 rd_ack = 0; rd_data_valid = 1;
        repeat (3) begin
            rd_data = 16'($urandom);
            @(posedge clk); #1;
        end
        reset = 0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1;
        sb_en = 1;
        exp_q.delete();
        @(negedge clk);
        n_cmp++;
        if ({rd_req, fifo_wr, fifo_data, rd_addr, buffer_select, frame_busy, frame_end, err_flags} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_data: req=%b wr=%b dat=%h addr=%h sel=%b busy=%b fe=%b err=%b, all must be 0",
                     rd_req, fifo_wr, fifo_data, rd_addr, buffer_select, frame_busy, frame_end, err_flags);
        end
        @(posedge clk); #1 rd_data_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (err_flags !== 2'b10) begin
            n_bad++;
            $display("FAIL late_beat_err: err_flags=%b expected 10", err_flags);
        end
    endtask

    task automatic test_first_burst();
        logic [22:0] a;
        bit ok;
        int w0;
        do_reset();
        w0 = n_wr;
        pulse_vsync();
        @(negedge clk);
        n_cmp++;
        if (rd_req !== 1'b0) begin
            n_bad++;
            $display("FAIL req_n1: rd_req=%b expected 0 one cycle after vsync", rd_req);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (rd_req !== 1'b1 || rd_addr !== 23'h0) begin
            n_bad++;
            $display("FAIL req_n2: rd_req=%b addr=%h expected 1 / 000000", rd_req, rd_addr);
        end
        serve_burst(-1, -1, a, ok);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (!ok || n_wr - w0 !== BL || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL first_burst: ok=%0d writes=%0d pending=%0d expected 1/%0d/0", ok, n_wr - w0, exp_q.size(), BL);
        end
        serve_burst(-1, -1, a, ok);
        n_cmp++;
        if (!ok || a !== 23'h8) begin
            n_bad++;
            $display("FAIL second_addr: ok=%0d addr=%h expected 000008", ok, a);
        end
    endtask

    task automatic test_fifo_space();
        logic [22:0] a;
        bit ok;
        bit seen;
        do_reset();
        fifo_wrusedw = 12'd2041;
        pulse_vsync();
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rd_req === 1'b1) seen = 1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL space_2041: rd_req seen=%b expected 0", seen);
        end
        @(posedge clk); #1 fifo_wrusedw = 12'd2040;
        repeat (10) begin
            @(negedge clk);
            if (rd_req === 1'b1) seen = 1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL space_2040: rd_req seen=%b expected 0", seen);
        end
        @(posedge clk); #1 fifo_wrusedw = 12'd0; fifo_wrfull = 1;
        repeat (10) begin
            @(negedge clk);
            if (rd_req === 1'b1) seen = 1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL space_full: rd_req seen=%b expected 0", seen);
        end
        @(posedge clk); #1 fifo_wrfull = 0; fifo_wrusedw = 12'd2039;
        serve_burst(-1, -1, a, ok);
        n_cmp++;
        if (!ok || a !== 23'h0) begin
            n_bad++;
            $display("FAIL space_2039: ok=%0d addr=%h expected 1 / 000000", ok, a);
        end
    endtask

    task automatic test_full_frame();
        int bursts, bad, w0, f0;
        logic [22:0] last_a;
        do_reset();
        w0 = n_wr; f0 = n_fe;
        pulse_vsync();
        run_frame(BUF_A, 1'b0, -1, -1, bursts, bad, last_a);
        n_cmp++;
        if (bursts !== NB || bad !== 0 || last_a !== BUF_A + 23'(TB_FRAME - BL)) begin
            n_bad++;
            $display("FAIL full_frame: bursts=%0d bad=%0d last=%h expected %0d/0/%h",
                     bursts, bad, last_a, NB, BUF_A + 23'(TB_FRAME - BL));
        end
        n_cmp++;
        if (n_wr - w0 !== TB_FRAME || n_fe - f0 !== 1 || frame_busy !== 1'b0 || rd_req !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_totals: writes=%0d frame_end=%0d busy=%b req=%b expected %0d/1/0/0",
                     n_wr - w0, n_fe - f0, frame_busy, rd_req, TB_FRAME);
        end
    endtask

    task automatic test_swap();
        int bursts, bad;
        logic [22:0] last_a, a;
        bit ok;
        do_reset();
        pulse_vsync();
        run_frame(BUF_A, 1'b0, 2, 5, bursts, bad, last_a);
        n_cmp++;
        if (bursts !== NB || bad !== 0 || buffer_select !== 1'b0) begin
            n_bad++;
            $display("FAIL swap_frame1: bursts=%0d bad=%0d sel=%b expected %0d/0/0", bursts, bad, buffer_select, NB);
        end
        pulse_vsync();
        run_frame(BUF_B, 1'b1, -1, -1, bursts, bad, last_a);
        n_cmp++;
        if (bursts !== NB || bad !== 0 || last_a !== BUF_B + 23'(TB_FRAME - BL)) begin
            n_bad++;
            $display("FAIL swap_frame2: bursts=%0d bad=%0d last=%h expected %0d/0/%h",
                     bursts, bad, last_a, NB, BUF_B + 23'(TB_FRAME - BL));
        end
        pulse_vsync();
        serve_burst(-1, -1, a, ok);
        n_cmp++;
        if (!ok || a !== BUF_B || buffer_select !== 1'b1) begin
            n_bad++;
            $display("FAIL single_swap: ok=%0d addr=%h sel=%b expected 1/%h/1", ok, a, buffer_select, BUF_B);
        end
    endtask

    task automatic test_errors();
        logic [22:0] a;
        bit ok;
        int w0;
        do_reset();
        w0 = n_wr;
        pulse_vsync();
        serve_burst(3, -1, a, ok);
        fifo_wrusedw = 12'd2045;
        @(posedge clk); #1;
        rd_data = 16'hDEAD; rd_data_valid = 1;
        @(posedge clk); #1 rd_data_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (err_flags !== 2'b11 || rd_req !== 1'b0 || frame_busy !== 1'b1 || buffer_select !== 1'b0) begin
            n_bad++;
            $display("FAIL err_flags: err=%b req=%b busy=%b sel=%b expected 11/0/1/0",
                     err_flags, rd_req, frame_busy, buffer_select);
        end
        @(posedge clk); #1 fifo_wrusedw = 12'd0;
        serve_burst(-1, -1, a, ok);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (!ok || a !== 23'h8 || n_wr - w0 !== 2 * BL || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL err_continue: ok=%0d addr=%h writes=%0d pending=%0d expected 1/000008/%0d/0",
                     ok, a, n_wr - w0, exp_q.size(), 2 * BL);
        end
    endtask

    initial begin
        test_reset();
        test_first_burst();
        test_fifo_space();
        test_full_frame();
        test_swap();
        test_errors();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
